// File: rtl/tdc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : tdc_spi_pkg
// Brief  : Shared opcodes, address map, widths and FSM encoding for the
//          TDC SPI read-port responder.
// Rev    : 1.0
// ============================================================================
package tdc_spi_pkg;

    localparam int WORD_W = 24;
    localparam int CMD_W  = 8;

    localparam logic [CMD_W-1:0] READ1_INST  = 8'h90;
    localparam logic [CMD_W-1:0] READ2_INST  = 8'h9B;
    localparam logic [3:0]       READ_NIBBLE = 4'b1001;

    localparam logic [3:0] ADDR_RES0 = 4'h0;
    localparam logic [3:0] ADDR_RES1 = 4'h1;
    localparam logic [3:0] ADDR_RES2 = 4'h2;
    localparam logic [3:0] ADDR_CAL1 = 4'hB;
    localparam logic [3:0] ADDR_CAL2 = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    function automatic logic is_read(input logic [CMD_W-1:0] op);
        return op[CMD_W-1:CMD_W-4] == READ_NIBBLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_spi_sync.sv
`default_nettype none
// ============================================================================
// Module : tdc_spi_sync
// Brief  : Two-flop synchronizer plus one edge-detect flop for an async pin.
// Rev    : 1.0
// ============================================================================
module tdc_spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    // Resets to 0 so a pin already low at reset release produces no fall.
    logic [2:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[1:0], async_in};
        end
    end

    assign rise =  r_sh[1] & ~r_sh[2];
    assign fall = ~r_sh[1] &  r_sh[2];

endmodule
`default_nettype wire

// File: rtl/tdc_spi_resp.sv
`default_nettype none
// ============================================================================
// Module : tdc_spi_resp
// Brief  : Oversampling SPI responder emulating the TDC read port; 8-bit read
//          opcode then auto-incrementing 24-bit words MSB first on dout.
//          Optional macro TDC_SPI_RESP_SNAPSHOT_EN: read from a shadow bank
//          captured at the csb falling edge.
// Rev    : 1.0
// ============================================================================
module tdc_spi_resp
    import tdc_spi_pkg::*;
#(
    parameter int SCLK_MIN_HALF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csb,
    input  logic              sclk,
    input  logic              din,
    output logic              dout,
    input  logic              reg_we,
    input  logic [3:0]        reg_addr,
    input  logic [WORD_W-1:0] reg_wdata,
    output logic              busy,
    output logic              cmd_strobe,
    output logic [CMD_W-1:0]  cmd_code,
    output logic              word_done,
    output logic              bad_cmd
);

    logic w_csb_rise, w_csb_fall, w_sclk_rise, w_sclk_fall;
    logic r_din_meta, r_din_sync;

    tdc_spi_sync u_sync_csb (
        .clk      (clk),
        .rst      (rst),
        .async_in (csb),
        .rise     (w_csb_rise),
        .fall     (w_csb_fall)
    );

    tdc_spi_sync u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_meta <= 1'b0;
            r_din_sync <= 1'b0;
        end else begin
            r_din_meta <= din;
            r_din_sync <= r_din_meta;
        end
    end

    logic [WORD_W-1:0] r_res0, r_res1, r_res2, r_cal1, r_cal2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res0 <= '0;
            r_res1 <= '0;
            r_res2 <= '0;
            r_cal1 <= '0;
            r_cal2 <= '0;
        end else if (reg_we) begin
            case (reg_addr)
                ADDR_RES0: r_res0 <= reg_wdata;
                ADDR_RES1: r_res1 <= reg_wdata;
                ADDR_RES2: r_res2 <= reg_wdata;
                ADDR_CAL1: r_cal1 <= reg_wdata;
                ADDR_CAL2: r_cal2 <= reg_wdata;
                default:   ;
            endcase
        end
    end

    // Register values with a same-cycle write already merged in.
    logic [WORD_W-1:0] w_res0_b, w_res1_b, w_res2_b, w_cal1_b, w_cal2_b;
    assign w_res0_b = (reg_we && reg_addr == ADDR_RES0) ? reg_wdata : r_res0;
    assign w_res1_b = (reg_we && reg_addr == ADDR_RES1) ? reg_wdata : r_res1;
    assign w_res2_b = (reg_we && reg_addr == ADDR_RES2) ? reg_wdata : r_res2;
    assign w_cal1_b = (reg_we && reg_addr == ADDR_CAL1) ? reg_wdata : r_cal1;
    assign w_cal2_b = (reg_we && reg_addr == ADDR_CAL2) ? reg_wdata : r_cal2;

    state_t            r_state, w_state_n;
    logic [4:0]        r_bit_cnt, w_bit_cnt_n;
    logic [CMD_W-2:0]  r_cmd, w_cmd_n;
    logic [WORD_W-1:0] r_shift, w_shift_n;
    logic [3:0]        r_addr, w_addr_n;
    logic              r_dout, w_dout_n;
    logic [CMD_W-1:0]  r_cmd_code, w_cmd_code_n;
    logic              r_strobe, w_strobe_n;
    logic              r_done, w_done_n;
    logic              r_bad, w_bad_n;

    logic [CMD_W-1:0]  w_opcode;
    logic [3:0]        w_load_addr;
    logic [WORD_W-1:0] w_load_word;
    logic [WORD_W-1:0] w_src0, w_src1, w_src2, w_src3, w_src4;

    assign w_opcode = {r_cmd, r_din_sync};

    // First word comes from the opcode's address; later words from addr+1.
    assign w_load_addr = (r_state == ST_CMD) ? w_opcode[3:0] : r_addr + 4'd1;

`ifdef TDC_SPI_RESP_SNAPSHOT_EN
    logic [WORD_W-1:0] r_sh_res0, r_sh_res1, r_sh_res2, r_sh_cal1, r_sh_cal2;
    logic              w_snap;

    assign w_snap = (r_state == ST_IDLE) && w_csb_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_res0 <= '0;
            r_sh_res1 <= '0;
            r_sh_res2 <= '0;
            r_sh_cal1 <= '0;
            r_sh_cal2 <= '0;
        end else if (w_snap) begin
            r_sh_res0 <= w_res0_b;
            r_sh_res1 <= w_res1_b;
            r_sh_res2 <= w_res2_b;
            r_sh_cal1 <= w_cal1_b;
            r_sh_cal2 <= w_cal2_b;
        end
    end

    assign w_src0 = r_sh_res0;
    assign w_src1 = r_sh_res1;
    assign w_src2 = r_sh_res2;
    assign w_src3 = r_sh_cal1;
    assign w_src4 = r_sh_cal2;
`else
    assign w_src0 = w_res0_b;
    assign w_src1 = w_res1_b;
    assign w_src2 = w_res2_b;
    assign w_src3 = w_cal1_b;
    assign w_src4 = w_cal2_b;
`endif

    always_comb begin
        w_load_word = '0;
        case (w_load_addr)
            ADDR_RES0: w_load_word = w_src0;
            ADDR_RES1: w_load_word = w_src1;
            ADDR_RES2: w_load_word = w_src2;
            ADDR_CAL1: w_load_word = w_src3;
            ADDR_CAL2: w_load_word = w_src4;
            default:   w_load_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_cmd      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_dout     <= 1'b0;
            r_cmd_code <= '0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_cmd      <= w_cmd_n;
            r_shift    <= w_shift_n;
            r_addr     <= w_addr_n;
            r_dout     <= w_dout_n;
            r_cmd_code <= w_cmd_code_n;
            r_strobe   <= w_strobe_n;
            r_done     <= w_done_n;
            r_bad      <= w_bad_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_bit_cnt_n  = r_bit_cnt;
        w_cmd_n      = r_cmd;
        w_shift_n    = r_shift;
        w_addr_n     = r_addr;
        w_dout_n     = r_dout;
        w_cmd_code_n = r_cmd_code;
        w_strobe_n   = 1'b0;
        w_done_n     = 1'b0;
        w_bad_n      = 1'b0;

        // csb release wins over everything: abandon the shift silently.
        if (w_csb_rise) begin
            w_state_n = ST_IDLE;
            w_dout_n  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_csb_fall) begin
                        w_state_n   = ST_CMD;
                        w_bit_cnt_n = '0;
                        w_cmd_n     = '0;
                        w_dout_n    = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_cmd_n     = w_opcode[CMD_W-2:0];
                        w_bit_cnt_n = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_n = '0;
                            if (is_read(w_opcode)) begin
                                w_strobe_n   = 1'b1;
                                w_cmd_code_n = w_opcode;
                                w_addr_n     = w_opcode[3:0];
                                w_shift_n    = w_load_word;
                                w_state_n    = ST_DATA;
                            end else begin
                                w_bad_n   = 1'b1;
                                w_state_n = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sclk_fall) begin
                        w_dout_n  = r_shift[WORD_W-1];
                        w_shift_n = {r_shift[WORD_W-2:0], 1'b0};
                    end else if (w_sclk_rise) begin
                        if (r_bit_cnt == 5'd23) begin
                            w_bit_cnt_n = '0;
                            w_done_n    = 1'b1;
                            w_addr_n    = r_addr + 4'd1;
                            w_shift_n   = w_load_word;
                        end else begin
                            w_bit_cnt_n = r_bit_cnt + 5'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                    w_dout_n = 1'b0;
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_dout_n  = 1'b0;
                end
            endcase
        end
    end

    // Clocks since the last synchronized sclk edge, saturating.
    logic [7:0] r_half_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half_cnt <= '0;
        end else if (w_sclk_rise || w_sclk_fall) begin
            r_half_cnt <= '0;
        end else if (r_half_cnt != 8'hFF) begin
            r_half_cnt <= r_half_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_CMD || r_state == ST_DATA) &&
            (w_sclk_rise || w_sclk_fall)) begin
            assert (r_half_cnt >= 8'(SCLK_MIN_HALF - 1));
        end
    end

    assign dout       = r_dout;
    assign busy       = (r_state != ST_IDLE);
    assign cmd_strobe = r_strobe;
    assign cmd_code   = r_cmd_code;
    assign word_done  = r_done;
    assign bad_cmd    = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_tdc_spi_resp.sv
`default_nettype none
// ============================================================================
// Module : tb_tdc_spi_resp
// Brief  : Scoreboard bench for tdc_spi_resp; directed SPI read transactions.
// Rev    : 1.0
// ============================================================================
module tb_tdc_spi_resp;
    import tdc_spi_pkg::*;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst, csb, sclk, din, reg_we;
    logic [3:0]  reg_addr;
    logic [23:0] reg_wdata;
    logic        dout, busy, cmd_strobe, word_done, bad_cmd;
    logic [7:0]  cmd_code;

    tdc_spi_resp #(.SCLK_MIN_HALF(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .csb        (csb),
        .sclk       (sclk),
        .din        (din),
        .dout       (dout),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .busy       (busy),
        .cmd_strobe (cmd_strobe),
        .cmd_code   (cmd_code),
        .word_done  (word_done),
        .bad_cmd    (bad_cmd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_word_q[$];
    logic [7:0]  exp_cmd_q[$];
    int          exp_bad_q[$];

    logic [23:0] mon_sh   = '0;
    logic [23:0] mon_word = '0;
    int          mon_rise = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Master-side capture of miso, sampled on sclk rise after the 8 command bits.
    always @(negedge csb) mon_rise = 0;

    always @(posedge sclk) begin
        if (csb === 1'b0) begin
            if (mon_rise >= 8) begin
                mon_sh = {mon_sh[22:0], dout};
                if (((mon_rise - 8) % 24) == 23) mon_word = mon_sh;
            end
            mon_rise++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (word_done) begin
                check("word_done_pending", 32'(exp_word_q.size() != 0), 1);
                if (exp_word_q.size() != 0) check("miso_word", mon_word, exp_word_q.pop_front());
            end
            if (cmd_strobe) begin
                check("cmd_strobe_pending", 32'(exp_cmd_q.size() != 0), 1);
                if (exp_cmd_q.size() != 0) check("cmd_code", cmd_code, exp_cmd_q.pop_front());
            end
            if (bad_cmd) begin
                check("bad_cmd_pending", 32'(exp_bad_q.size() != 0), 1);
                if (exp_bad_q.size() != 0) void'(exp_bad_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    // abort_at >= 0 raises csb after that many data bits.
    task automatic spi_xfer(input logic [7:0] op, input int nbits, input int abort_at,
                            input bit ignore_chk);
        logic seen;
        seen = 1'b0;
        csb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_rise", busy, 0);
        @(negedge clk);
        check("busy_rise", busy, 1);
        @(negedge clk);
        for (int i = 0; i < 8 + nbits; i++) begin
            if (abort_at >= 0 && i == 8 + abort_at) break;
            din = (i < 8) ? op[7 - i] : 1'b0;
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            if (i >= 8) seen = seen | dout;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
        csb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_hold", busy, 1);
        @(negedge clk);
        check("busy_fall", busy, 0);
        if (ignore_chk) check("ignore_miso_zero", seen, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; csb = 1'b0; sclk = 1'b0; din = 1'b0;
        reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_pulses", {word_done, cmd_strobe, bad_cmd}, 0);
        rst = 1'b0;

        // csb already low at reset release must not start a transaction
        repeat (8) @(negedge clk);
        check("busy_low_csb_after_rst", busy, 0);
        csb = 1'b1;
        repeat (6) @(negedge clk);

        wr(ADDR_RES0, 24'h123456);
        wr(ADDR_RES1, 24'hABCDEF);
        wr(ADDR_RES2, 24'h000001);
        exp_cmd_q.push_back(READ1_INST);
        exp_word_q.push_back(24'h123456);
        exp_word_q.push_back(24'hABCDEF);
        exp_word_q.push_back(24'h000001);
        spi_xfer(READ1_INST, 72, -1, 1'b0);

        wr(ADDR_CAL1, 24'hFFFFFF);
        wr(ADDR_CAL2, 24'h800000);
        exp_cmd_q.push_back(READ2_INST);
        exp_word_q.push_back(24'hFFFFFF);
        exp_word_q.push_back(24'h800000);
        spi_xfer(READ2_INST, 48, -1, 1'b0);

        // unmapped write ignored; address 0xF wraps to RES0
        wr(4'hF, 24'h111111);
        exp_cmd_q.push_back(8'h9F);
        exp_word_q.push_back(24'h000000);
        exp_word_q.push_back(24'h123456);
        spi_xfer(8'h9F, 48, -1, 1'b0);

        exp_bad_q.push_back(1);
        spi_xfer(8'h55, 24, -1, 1'b1);
        exp_cmd_q.push_back(READ1_INST);
        exp_word_q.push_back(24'h123456);
        spi_xfer(READ1_INST, 24, -1, 1'b0);

        exp_cmd_q.push_back(READ1_INST);
        spi_xfer(READ1_INST, 24, 10, 1'b0);
        exp_cmd_q.push_back(READ1_INST);
        exp_word_q.push_back(24'h123456);
        spi_xfer(READ1_INST, 24, -1, 1'b0);

        exp_cmd_q.push_back(READ1_INST);
        exp_word_q.push_back(24'h123456);
`ifdef TDC_SPI_RESP_SNAPSHOT_EN
        exp_word_q.push_back(24'hABCDEF);
`else
        exp_word_q.push_back(24'h777777);
`endif
        fork
            spi_xfer(READ1_INST, 48, -1, 1'b0);
            begin
                repeat ((8 + 6) * 2 * H + 4) @(negedge clk);
                wr(ADDR_RES1, 24'h777777);
            end
        join

        repeat (10) @(negedge clk);
        check("word_q_drained", exp_word_q.size(), 0);
        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("bad_q_drained", exp_bad_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdc_spi_resp.md
# tdc_spi_resp

SPI responder that emulates the TDC read port in the FPGA1 test/emulation build, i.e. the slave end of the TDC read sequence (opcode 0x90 then 0x9B, 24-bit results MSB first). It oversamples csb/sclk/mosi on the system clock, decodes the 8-bit read opcode, and shifts auto-incrementing 24-bit result words out on miso. Result and calibration values are loaded through a parallel write port by local stimulus logic.

## Interface
- SCLK_MIN_HALF, 4, minimum sclk half-period in clk cycles that the responder supports; documentation and assertion only.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- csb  in  1  SPI chip select, active low; asynchronous to clk.
- sclk  in  1  SPI clock, CPOL=0; asynchronous to clk.
- din  in  1  MOSI from the master.
- dout  out  1  MISO to the master.
- reg_we  in  1  parallel write strobe.
- reg_addr  in  4  write address.
- reg_wdata  in  24  write data.
- busy  out  1  high while a transaction is in progress (csb low after sync).
- cmd_strobe  out  1  one-cycle pulse when a valid read opcode has been decoded.
- cmd_code  out  8  last decoded opcode; held until the next decode.
- word_done  out  1  one-cycle pulse after each complete 24-bit word.
- bad_cmd  out  1  one-cycle pulse when an opcode with upper nibble other than 4'b1001 is decoded.

## Operation
- Synchronizer: csb, sclk and din each pass through 2 flops; a third sclk/csb flop provides edge detection.
- Address map, 24-bit: 0x0 RES0, 0x1 RES1, 0x2 RES2, 0xB CAL1, 0xC CAL2. All other addresses read 0; writes to them are ignored.
- Opcode: bits [7:4]=4'b1001 is a read; bits [3:0] are the start address. Address auto-increments after each word and wraps from 0xF to 0x0.
- FSM states:
  - IDLE: waits for a synchronized csb falling edge, then goes to CMD with bit_cnt=0.
  - CMD: samples din on each sclk rise and shifts it into the MSB-first cmd register. After the 8th rise:
    - valid opcode: pulse cmd_strobe, load the first word, go to DATA;
    - invalid opcode: pulse bad_cmd, go to IGNORE.
  - DATA: on each sclk fall, drives dout = shift[23] and shifts left. After the 24th rise of a word, pulses word_done, increments the address and loads the next word.
  - IGNORE: holds dout=0 until csb rises.
- A csb rising edge from any state returns the FSM to IDLE. The current shift is abandoned, no word_done is issued, and dout goes to 0.
- Same-cycle reg_we and internal word load: the load sees the new reg_wdata (write-first bypass).

## Timing
- Reset values: dout=0, busy=0, all pulses=0, cmd_code=0, all registers 0, FSM=IDLE.
- Pin-to-action latency is 3 clk: 2 sync flops plus 1 edge-detect flop.
- dout changes 3 clk after each sclk falling pin edge. The first data bit (word bit 23) appears after the 8th sclk fall of the command.
- A master that samples on sclk rising edges therefore requires an sclk half-period of at least SCLK_MIN_HALF clk cycles.
- busy rises 3 clk after csb falls and drops 3 clk after csb rises.
- After reset release, a transaction starts only on a new csb falling edge; a csb already held low is ignored until it goes high and falls again.
- Reset asserted mid-transaction aborts the transaction immediately, with no pulses.
- Counters: bit_cnt is 5 bits and counts 0–7 in CMD and 0–23 in DATA. The 4-bit address counter wraps.

## Configuration
- TDC_SPI_RESP_SNAPSHOT_EN defined: on the csb falling edge all five registers are copied into a shadow bank, and every word in the transaction reads from the shadow. reg_we during the transaction affects only the next transaction.
- Undefined: each word is loaded from the live registers at its word boundary, with the write-first bypass applying.

## Structure
- Shared package tdc_spi_pkg holds:
  - opcode constants READ1_INST=8'h90 and READ2_INST=8'h9B;
  - READ_NIBBLE=4'b1001;
  - address constants ADDR_RES0..2=4'h0..2, ADDR_CAL1=4'hB, ADDR_CAL2=4'hC;
  - WORD_W=24 and CMD_W=8;
  - FSM state encoding.
- One sub-module, tdc_spi_sync, implements the 2-flop synchronizer plus edge detect and is instantiated for csb and sclk; din uses only the 2-flop path.

## Test plan
- Load RES0..2 = 0x123456, 0xABCDEF, 0x000001. Master sends 0x90 and clocks 72 bits -> miso carries the three words MSB first, cmd_strobe fires once with cmd_code=0x90, word_done fires 3 times.
- Load CAL1=0xFFFFFF, CAL2=0x800000. Master sends 0x9B and clocks 48 bits -> miso carries 0xFFFFFF then 0x800000.
- Master sends 0x9F and clocks 48 bits -> first word is 0x000000 (address 0xF), second is RES0 (address wraps to 0x0).
- Master sends 0x55 -> bad_cmd pulses once, miso stays 0 for 24 clocks, and the next valid 0x90 transaction reads correctly.
- Raise csb after 10 data bits -> no word_done, busy drops 3 clk later, and the next 0x90 restarts at RES0 bit 23.
- Write RES1 = 0x777777 via reg_we during word 0 of a 0x90 read -> word 1 reads the original RES1 with TDC_SPI_RESP_SNAPSHOT_EN defined, and 0x777777 without it.
